// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's-complement, with early exit.
// Latency: k cycles from start edge to done (k = bits examined, 1..WIDTH).
// No backpressure: start is taken while idle or on the completing edge, and ignored otherwise.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW-1:0] IDX_LSB = '0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             signed_r;
   logic [IW-1:0]    idx;

   logic bit_a;
   logic bit_b;
   logic differ;
   logic sign_pos;
   logic finish;
   logic res_gt;
   logic res_lt;

   assign busy = (state == RUN);

   // Decide the outcome of the bit pair currently under examination.
   always_comb begin
      bit_a    = a_r[idx];
      bit_b    = b_r[idx];
      differ   = bit_a ^ bit_b;
      // A differing sign bit inverts the sense: the operand holding the 1 is negative.
      sign_pos = signed_r && (idx == IDX_MSB);
      res_gt   = differ && (sign_pos ? bit_b : bit_a);
      res_lt   = differ && (sign_pos ? bit_a : bit_b);
      finish   = differ || (idx == IDX_LSB);
   end

   // Control FSM, operand capture and registered result flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         signed_r <= 1'b0;
         idx      <= IDX_MSB;
         done     <= 1'b0;
         eq       <= 1'b0;
         gt       <= 1'b0;
         lt       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r      <= a;
                  b_r      <= b;
                  signed_r <= signed_mode;
                  idx      <= IDX_MSB;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (finish) begin
                  eq   <= ~differ;
                  gt   <= res_gt;
                  lt   <= res_lt;
                  done <= 1'b1;
                  // The completing edge already counts as idle, so a start seen here
                  // launches the next compare with no gap (issue interval equals k).
                  if (start) begin
                     a_r      <= a;
                     b_r      <= b;
                     signed_r <= signed_mode;
                     idx      <= IDX_MSB;
                     state    <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  idx <= idx - IDX_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (WIDTH=8 main instance, WIDTH=1 corner instance).
// Latency: measured in clock edges from the start edge E0 to the edge that registers done.
// Inputs driven #1 after rising edges, outputs sampled #1 after rising edges.
module tb_serial_mag_comparator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       signed_mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic       eq;
   logic       gt;
   logic       lt;

   logic       start1;
   logic       signed1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       busy1;
   logic       done1;
   logic       eq1;
   logic       gt1;
   logic       lt1;

   int checks = 0;
   int errors = 0;

   serial_mag_comparator #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
   );

   serial_mag_comparator #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present a request so that it is sampled at the next rising edge (E0); returns #1 after E0.
   task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic sm);
      @(negedge clk);
      a = va; b = vb; signed_mode = sm; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count edges until done is seen (lat = -1 on timeout) and busy cycles along the way.
   task automatic run_until_done(output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int n = 1; n <= 20; n++) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
      a = '0; b = '0; signed_mode = 1'b0; a1 = '0; b1 = '0; signed1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
      end
      checks++;
      if ({eq, gt, lt} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got=%b exp=000", {eq, gt, lt});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_equal;
      int lat, bcnt;
      issue(8'hA5, 8'hA5, 1'b0);
      run_until_done(lat, bcnt);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL equal_latency got=%0d exp=8", lat); end
      checks++;
      if (bcnt !== 8) begin errors++; $display("FAIL equal_busy_cycles got=%0d exp=8", bcnt); end
      checks++;
      if ({eq, gt, lt} !== 3'b100) begin
         errors++; $display("FAIL equal_flags got=%b exp=100", {eq, gt, lt});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy, eq, gt, lt} !== 5'b00100) begin
         errors++; $display("FAIL equal_after got=%b exp=00100", {done, busy, eq, gt, lt});
      end
   endtask

   task automatic test_msb_differ;
      int lat, bcnt;
      issue(8'h80, 8'h7F, 1'b0);
      run_until_done(lat, bcnt);
      checks++;
      if (lat !== 1 || {eq, gt, lt} !== 3'b010) begin
         errors++; $display("FAIL msb_unsigned lat=%0d flags=%b exp lat=1 flags=010", lat, {eq, gt, lt});
      end
      issue(8'h80, 8'h7F, 1'b1);
      run_until_done(lat, bcnt);
      checks++;
      if (lat !== 1 || {eq, gt, lt} !== 3'b001) begin
         errors++; $display("FAIL msb_signed lat=%0d flags=%b exp lat=1 flags=001", lat, {eq, gt, lt});
      end
   endtask

   task automatic test_input_change;
      int lat, bcnt;
      issue(8'h12, 8'h13, 1'b0);
      @(posedge clk);
      #1 a = 8'hFF;
      checks++;
      if ({eq, gt, lt} !== 3'b001 || busy !== 1'b1) begin
         errors++; $display("FAIL change_midrun busy=%b flags=%b exp busy=1 flags=001 (prior hold)", busy, {eq, gt, lt});
      end
      run_until_done(lat, bcnt);
      checks++;
      if (lat + 1 !== 8) begin errors++; $display("FAIL change_latency got=%0d exp=8", lat + 1); end
      checks++;
      if ({eq, gt, lt} !== 3'b001) begin
         errors++; $display("FAIL change_flags got=%b exp=001", {eq, gt, lt});
      end
   endtask

   task automatic test_busy_ignore;
      int lat, bcnt, extra;
      issue(8'h55, 8'h55, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      a = 8'h00; b = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      run_until_done(lat, bcnt);
      checks++;
      if (lat + 3 !== 8) begin errors++; $display("FAIL ignore_latency got=%0d exp=8", lat + 3); end
      checks++;
      if ({eq, gt, lt} !== 3'b100) begin
         errors++; $display("FAIL ignore_flags got=%b exp=100", {eq, gt, lt});
      end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL ignore_extra_activity got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_midrun;
      int lat, bcnt;
      issue(8'h3C, 8'h3C, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, eq, gt, lt} !== 5'b00000) begin
         errors++; $display("FAIL reset_midrun got=%b exp=00000", {busy, done, eq, gt, lt});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL reset_release got=%b exp=00", {busy, done});
      end
      a = 8'hFF; b = 8'hFE; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      run_until_done(lat, bcnt);
      checks++;
      if (lat !== 8 || {eq, gt, lt} !== 3'b010) begin
         errors++; $display("FAIL reset_restart lat=%0d flags=%b exp lat=8 flags=010", lat, {eq, gt, lt});
      end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt, early;
      issue(8'hFE, 8'hFF, 1'b1);
      early = 0;
      for (int i = 1; i <= 7; i++) begin
         @(posedge clk);
         #1;
         if (done) early++;
      end
      checks++;
      if (early !== 0) begin errors++; $display("FAIL b2b_early_done got=%0d exp=0", early); end
      a = 8'h01; b = 8'h00; signed_mode = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      checks++;
      if ({done, busy, eq, gt, lt} !== 5'b11001) begin
         errors++; $display("FAIL b2b_first got=%b exp=11001", {done, busy, eq, gt, lt});
      end
      run_until_done(lat, bcnt);
      checks++;
      if (lat + 8 !== 16 || {eq, gt, lt} !== 3'b010) begin
         errors++; $display("FAIL b2b_second edge=%0d flags=%b exp edge=16 flags=010", lat + 8, {eq, gt, lt});
      end
   endtask

   task automatic test_width1;
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b0; signed1 = 1'b1; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("FAIL w1_busy got=%b exp=1", busy1); end
      @(posedge clk);
      #1;
      checks++;
      if ({done1, eq1, gt1, lt1} !== 4'b1001) begin
         errors++; $display("FAIL w1_signed got=%b exp=1001", {done1, eq1, gt1, lt1});
      end
      @(negedge clk);
      signed1 = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({done1, eq1, gt1, lt1} !== 4'b1010) begin
         errors++; $display("FAIL w1_unsigned got=%b exp=1010", {done1, eq1, gt1, lt1});
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_msb_differ();
      test_input_change();
      test_busy_ignore();
      test_reset_midrun();
      test_back_to_back();
      test_width1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Parametrised, bit-serial magnitude comparator. It is the multi-bit successor to the team's single-bit combinational comparator. Both operands are latched on a start strobe and compared MSB-first, one bit per clock, in unsigned or two's-complement mode. Compare terminates early at the first differing bit, and the result is reported as registered eq/gt/lt flags with a one-cycle done pulse. It sits beside datapath blocks that need area-cheap wide compares where latency is acceptable.

## Interface
- WIDTH, 8: operand width in bits; legal range is WIDTH >= 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a compare; sampled only while idle.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when a result is valid.
- eq  output  1  A == B for the last completed compare.
- gt  output  1  A > B for the last completed compare.
- lt  output  1  A < B for the last completed compare.

## Operation
- Two states, IDLE and RUN. busy = (state == RUN).
- IDLE, start=1 at a clock edge:
  - latch a, b and signed_mode into internal registers;
  - set the bit index to WIDTH-1;
  - go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge: examine latched bit pair a_r[idx], b_r[idx].
  - Bits differ, idx == WIDTH-1 and signed_mode=1: the sign bits differ, so the operand with the 1 is smaller. a_r=1 gives lt=1; otherwise gt=1.
  - Bits differ in any other case: a_r[idx]=1 gives gt=1; otherwise lt=1.
  - Bits equal and idx == 0: eq=1.
  - Bits equal and idx > 0: decrement idx and stay in RUN.
  - On any result: update eq/gt/lt, assert done, go to IDLE.
- Exactly one of eq/gt/lt is high after the first completed compare. All three are 0 only between reset and the first done.
- eq/gt/lt hold their value until the next done. They do not change during RUN.
- start while busy=1 is ignored. No queuing; the in-flight compare is unaffected.
- Input changes on a, b and signed_mode after the start edge have no effect on the current compare.
- The index counter is ceil(log2(WIDTH)) bits wide, minimum 1. It never wraps, because RUN exits at idx == 0.
- WIDTH=1:
  - signed_mode=1 treats the bit as sign-only, so 1 represents -1 and 0 represents 0.
  - Compare always takes one RUN cycle.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, eq=0, gt=0, lt=0, idx=WIDTH-1. Reset takes priority over start.
- Reset mid-RUN aborts the compare. No done pulse is issued and the flags are cleared.
- Let the start edge be E0 and let k be the number of bits examined:
  - k = WIDTH-p when the first differing bit is at position p;
  - k = WIDTH when the operands are equal.
- busy is high during cycles E0..E(k-1).
- done, eq, gt and lt are registered at edge Ek. done is high for exactly the cycle after Ek.
- Latency start→done is k cycles: minimum 1, maximum WIDTH.
- In the cycle done=1 the state is already IDLE. A start sampled at that edge is accepted, so the back-to-back issue interval equals k.
- done is never high for two consecutive cycles unless a new 1-bit-latency compare was started on the done cycle.

## Test plan
- WIDTH=8, unsigned, a=8'hA5, b=8'hA5:
  - busy for 8 cycles;
  - done at edge E8 with eq=1, gt=0, lt=0.
- WIDTH=8, a=8'h80, b=8'h7F:
  - signed_mode=0: done at E1 with gt=1;
  - repeat with signed_mode=1: done at E1 with lt=1.
- WIDTH=8, unsigned, a=8'h12, b=8'h13: done at E8 with lt=1.
  - Change a to 8'hFF at E2: result is still lt=1.
- Pulse start with a=8'h00, b=8'hFF during a busy compare of 8'h55 vs 8'h55:
  - the second request is ignored;
  - a single done arrives at E8 with eq=1.
- Start an equal compare, then drive rst_n=0 at E3:
  - no done pulse;
  - busy=0 and eq=gt=lt=0 from E3.
  - Then start with a=8'hFF, b=8'hFE at E5: done at E13 with gt=1.
- WIDTH=8, signed, a=8'hFE (-2), b=8'hFF (-1): done at E8 with lt=1.
  - Issue a new start on the done cycle with a=8'h01, b=8'h00: done at E16 with gt=1.
